// File: rtl/rob_ptr_ctrl.sv
// Reorder-buffer head/tail/occupancy controller: in-order allocation, completion
// tracking, contiguous multi-lane retirement and one-cycle flush recovery.
module rob_ptr_ctrl #(
  parameter  int NUM_ROB_ENTS   = 64,
  parameter  int DISPATCH_WIDTH = 2,
  parameter  int RETIRE_WIDTH   = 2,
  localparam int IDX_W          = $clog2(NUM_ROB_ENTS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DISPATCH_WIDTH-1:0]         alloc_req,
  output logic [DISPATCH_WIDTH-1:0]         alloc_gnt,
  output logic [DISPATCH_WIDTH*IDX_W-1:0]   alloc_idx,
  input  logic                              complete_valid,
  input  logic [IDX_W-1:0]                  complete_idx,
  output logic [RETIRE_WIDTH-1:0]           retire_valid,
  output logic [RETIRE_WIDTH*IDX_W-1:0]     retire_idx,
  input  logic                              retire_ready,
  input  logic                              flush,
  output logic [IDX_W:0]                    free_count,
  output logic                              full,
  output logic                              empty
);

  localparam int CNT_W = IDX_W + 1;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        head_q, head_d;
  logic [IDX_W-1:0]        tail_q, tail_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [NUM_ROB_ENTS-1:0] done_q, done_d;

  logic                    run;
  logic [CNT_W-1:0]        n_alloc;
  logic [CNT_W-1:0]        n_ret;
  logic [IDX_W-1:0]        comp_ofs;
  logic                    comp_hit;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= RUN;
    else      state_q <= state_d;
  end

  // FSM: next state. FLUSH lasts one cycle unless flush is held.
  always_comb begin
    state_d = flush ? FLUSH : RUN;
  end

  // FSM: outputs
  always_comb begin
    run = (state_q == RUN);
  end

  // NOTE: every always_comb output gets a default on entry, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    logic chain;
    alloc_gnt = '0;
    alloc_idx = '0;
    n_alloc   = '0;
    chain     = run;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      // The chain stops at the first clear or unfittable lane, keeping grants thermometer-coded.
      chain = chain && alloc_req[i] &&
              ({1'b0, count_q} + (CNT_W+1)'(i + 1) <= (CNT_W+1)'(NUM_ROB_ENTS));
      alloc_gnt[i]                  = chain;
      alloc_idx[i*IDX_W +: IDX_W]   = tail_q + IDX_W'(i);
      if (chain) n_alloc = n_alloc + CNT_W'(1);
    end
  end

  always_comb begin
    logic chain;
    retire_valid = '0;
    retire_idx   = '0;
    n_ret        = '0;
    chain        = run;
    for (int i = 0; i < RETIRE_WIDTH; i++) begin
      chain = chain && (CNT_W'(i) < count_q) && done_q[head_q + IDX_W'(i)];
      retire_valid[i]              = chain;
      retire_idx[i*IDX_W +: IDX_W] = head_q + IDX_W'(i);
      if (chain && retire_ready) n_ret = n_ret + CNT_W'(1);
    end
  end

  always_comb begin
    comp_ofs = complete_idx - head_q;
    comp_hit = run && complete_valid && ({1'b0, comp_ofs} < count_q);
  end

  assign free_count = CNT_W'(NUM_ROB_ENTS) - count_q;
  assign full       = (count_q == CNT_W'(NUM_ROB_ENTS));
  assign empty      = (count_q == '0);

  // NOTE: next-state logic uses blocking assignments so later writes to done_d refine earlier ones in order.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    done_d  = done_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      done_d  = '0;
    end else if (run) begin
      head_d  = head_q + IDX_W'(n_ret);
      tail_d  = tail_q + IDX_W'(n_alloc);
      count_d = count_q + n_alloc - n_ret;
      if (comp_hit) done_d[complete_idx] = 1'b1;
      for (int i = 0; i < RETIRE_WIDTH; i++)
        if (retire_ready && retire_valid[i]) done_d[head_q + IDX_W'(i)] = 1'b0;
      // Freshly granted slots lie outside the occupied window, so clearing them never hides a live completion.
      for (int i = 0; i < DISPATCH_WIDTH; i++)
        if (alloc_gnt[i]) done_d[tail_q + IDX_W'(i)] = 1'b0;
    end
  end

  // NOTE: the done bits are control state, not payload storage, so they are reset with the pointers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      done_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_rob_ptr_ctrl.sv
// Scoreboard bench for rob_ptr_ctrl: the driver queues hand-derived expected outputs
// per cycle and a negedge monitor pops and compares them.
module tb_rob_ptr_ctrl;

  localparam int N     = 64;
  localparam int IDX_W = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       alloc_req;
  logic [1:0]       alloc_gnt;
  logic [2*IDX_W-1:0] alloc_idx;
  logic             complete_valid;
  logic [IDX_W-1:0] complete_idx;
  logic [1:0]       retire_valid;
  logic [2*IDX_W-1:0] retire_idx;
  logic             retire_ready;
  logic             flush;
  logic [IDX_W:0]   free_count;
  logic             full;
  logic             empty;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string      name;
    logic [1:0] gnt;
    logic [5:0] a0, a1;
    logic [1:0] rv;
    logic [5:0] r0, r1;
    logic [6:0] free;
    logic       full, empty;
  } exp_t;

  exp_t sb_q[$];

  rob_ptr_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .alloc_req      (alloc_req),
    .alloc_gnt      (alloc_gnt),
    .alloc_idx      (alloc_idx),
    .complete_valid (complete_valid),
    .complete_idx   (complete_idx),
    .retire_valid   (retire_valid),
    .retire_idx     (retire_idx),
    .retire_ready   (retire_ready),
    .flush          (flush),
    .free_count     (free_count),
    .full           (full),
    .empty          (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(string n, logic [1:0] g, int a0, int a1,
                              logic [1:0] v, int r0, int r1, int cnt);
    exp_t e;
    e.name  = n;
    e.gnt   = g;
    e.a0    = 6'(a0);
    e.a1    = 6'(a1);
    e.rv    = v;
    e.r0    = 6'(r0);
    e.r1    = 6'(r1);
    e.free  = 7'(N - cnt);
    e.full  = (cnt == N);
    e.empty = (cnt == 0);
    return e;
  endfunction

  task automatic cyc(input logic [1:0] req, input logic cv, input int cidx,
                     input logic rr, input logic fl, input exp_t e);
    alloc_req      = req;
    complete_valid = cv;
    complete_idx   = 6'(cidx);
    retire_ready   = rr;
    flush          = fl;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are combinational every cycle, so one expectation is consumed per negedge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check({e.name, ".gnt"}, 32'(alloc_gnt), 32'(e.gnt));
        if (e.gnt[0]) check({e.name, ".aidx0"}, 32'(alloc_idx[5:0]), 32'(e.a0));
        if (e.gnt[1]) check({e.name, ".aidx1"}, 32'(alloc_idx[11:6]), 32'(e.a1));
        check({e.name, ".rv"}, 32'(retire_valid), 32'(e.rv));
        if (e.rv[0]) check({e.name, ".ridx0"}, 32'(retire_idx[5:0]), 32'(e.r0));
        if (e.rv[1]) check({e.name, ".ridx1"}, 32'(retire_idx[11:6]), 32'(e.r1));
        check({e.name, ".free"}, 32'(free_count), 32'(e.free));
        check({e.name, ".full"}, 32'(full), 32'(e.full));
        check({e.name, ".empty"}, 32'(empty), 32'(e.empty));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin : driver
    rst = 1'b0; alloc_req = '0; complete_valid = 1'b0; complete_idx = '0;
    retire_ready = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    cyc(2'b00, 0, 0, 0, 0, mk("reset", 2'b00, 0, 0, 2'b00, 0, 0, 0));

    // Fill the ROB two entries per cycle
    for (int k = 0; k < 32; k++)
      cyc(2'b11, 0, 0, 0, 0, mk("fill", 2'b11, 2*k, 2*k+1, 2'b00, 0, 0, 2*k));
    cyc(2'b11, 0, 0, 0, 0, mk("full_deny", 2'b00, 0, 0, 2'b00, 0, 0, 64));

    // Retire two at full while requesting: freed slots not reusable until next cycle
    cyc(2'b00, 1, 0, 0, 0, mk("full_cmp0", 2'b00, 0, 0, 2'b00, 0, 0, 64));
    cyc(2'b00, 1, 1, 0, 0, mk("full_cmp1", 2'b00, 0, 0, 2'b01, 0, 0, 64));
    cyc(2'b11, 0, 0, 1, 0, mk("full_ret_alloc", 2'b00, 0, 0, 2'b11, 0, 1, 64));
    cyc(2'b11, 0, 0, 0, 0, mk("realloc", 2'b11, 0, 1, 2'b00, 0, 0, 62));

    // Reach count=63, then a dual request gets only lane 0
    cyc(2'b00, 1, 2, 0, 0, mk("cmp2", 2'b00, 0, 0, 2'b00, 0, 0, 64));
    cyc(2'b00, 0, 0, 1, 0, mk("ret2", 2'b00, 0, 0, 2'b01, 2, 0, 64));
    cyc(2'b11, 0, 0, 0, 0, mk("cnt63", 2'b01, 2, 0, 2'b00, 0, 0, 63));
    cyc(2'b00, 0, 0, 0, 0, mk("cnt64", 2'b00, 0, 0, 2'b00, 0, 0, 64));

    // Flush from full
    cyc(2'b00, 0, 0, 0, 1, mk("pre_flush", 2'b00, 0, 0, 2'b00, 0, 0, 64));
    cyc(2'b11, 0, 0, 0, 0, mk("flush_state", 2'b00, 0, 0, 2'b00, 0, 0, 0));

    // Out-of-order completion: 1 then 0, retire both one cycle later
    cyc(2'b11, 0, 0, 0, 0, mk("a01", 2'b11, 0, 1, 2'b00, 0, 0, 0));
    cyc(2'b11, 0, 0, 0, 0, mk("a23", 2'b11, 2, 3, 2'b00, 0, 0, 2));
    cyc(2'b00, 1, 1, 1, 0, mk("cmp1", 2'b00, 0, 0, 2'b00, 0, 0, 4));
    cyc(2'b00, 1, 0, 1, 0, mk("cmp0", 2'b00, 0, 0, 2'b00, 0, 0, 4));
    cyc(2'b00, 0, 0, 1, 0, mk("ret01", 2'b00, 0, 0, 2'b11, 0, 1, 4));
    cyc(2'b00, 0, 0, 0, 0, mk("after_ret", 2'b00, 0, 0, 2'b00, 0, 0, 2));
    cyc(2'b00, 0, 0, 0, 1, mk("flush2", 2'b00, 0, 0, 2'b00, 0, 0, 2));
    cyc(2'b00, 0, 0, 0, 0, mk("flush2_state", 2'b00, 0, 0, 2'b00, 0, 0, 0));

    // Walk head to 62 in alloc/complete/complete/retire rounds
    for (int k = 0; k < 31; k++) begin
      cyc(2'b11, 0, 0,     0, 0, mk("walk_a", 2'b11, 2*k, 2*k+1, 2'b00, 0, 0, 0));
      cyc(2'b00, 1, 2*k,   0, 0, mk("walk_b", 2'b00, 0, 0, 2'b00, 0, 0, 2));
      cyc(2'b00, 1, 2*k+1, 0, 0, mk("walk_c", 2'b00, 0, 0, 2'b01, 2*k, 0, 2));
      cyc(2'b00, 0, 0,     1, 0, mk("walk_d", 2'b00, 0, 0, 2'b11, 2*k, 2*k+1, 2));
    end

    // Wrap: entries 62,63,0,1 retire across the index boundary
    cyc(2'b11, 0, 0,  0, 0, mk("w_a",   2'b11, 62, 63, 2'b00, 0, 0, 0));
    cyc(2'b11, 0, 0,  0, 0, mk("w_b",   2'b11, 0, 1, 2'b00, 0, 0, 2));
    cyc(2'b00, 1, 62, 0, 0, mk("w_c62", 2'b00, 0, 0, 2'b00, 0, 0, 4));
    cyc(2'b00, 1, 63, 0, 0, mk("w_c63", 2'b00, 0, 0, 2'b01, 62, 0, 4));
    cyc(2'b00, 1, 0,  0, 0, mk("w_c0",  2'b00, 0, 0, 2'b11, 62, 63, 4));
    cyc(2'b00, 1, 1,  0, 0, mk("w_c1",  2'b00, 0, 0, 2'b11, 62, 63, 4));
    cyc(2'b00, 0, 0,  1, 0, mk("w_r1",  2'b00, 0, 0, 2'b11, 62, 63, 4));
    cyc(2'b00, 0, 0,  1, 0, mk("w_r2",  2'b00, 0, 0, 2'b11, 0, 1, 2));
    cyc(2'b11, 0, 0,  0, 0, mk("w_empty", 2'b11, 2, 3, 2'b00, 0, 0, 0));

    // Build count=10, then flush with a same-cycle completion
    for (int k = 0; k < 4; k++)
      cyc(2'b11, 0, 0, 0, 0, mk("f_fill", 2'b11, 4+2*k, 5+2*k, 2'b00, 0, 0, 2+2*k));
    cyc(2'b00, 1, 2, 0, 1, mk("flush_cv", 2'b00, 0, 0, 2'b00, 0, 0, 10));
    cyc(2'b11, 0, 0, 0, 0, mk("flush_hold", 2'b00, 0, 0, 2'b00, 0, 0, 0));
    cyc(2'b11, 0, 0, 0, 0, mk("flush_resume", 2'b11, 0, 1, 2'b00, 0, 0, 0));

    // Mid-operation reset beats a simultaneous flush: next cycle is RUN
    rst = 1'b0;
    cyc(2'b00, 0, 0, 0, 1, mk("rst_mid", 2'b00, 0, 0, 2'b00, 0, 0, 2));
    rst = 1'b1;
    cyc(2'b11, 0, 0, 0, 0, mk("rst_run", 2'b11, 0, 1, 2'b00, 0, 0, 0));

    alloc_req = '0; flush = 1'b0;
    @(negedge clk);
    #1;
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
